// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: instruction field geometry, widths and the fetch FSM encoding.
// The vector-load states exist only when FETCH_RESET_VECTOR_EN is defined.
package fetch_unit_pkg;

  localparam int OPCODE_W = 5;
  localparam int REG_W    = 3;
  localparam int SHMNT_W  = 5;
  localparam int INST_W   = 16;
  localparam int ADDR_W   = 32;

  localparam int OPCODE_LSB = 11;
  localparam int RS_LSB     = 8;
  localparam int RD_LSB     = 5;
  localparam int SHMNT_LSB  = 0;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 5'd0;

`ifdef FETCH_RESET_VECTOR_EN
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    VEC_HI = 2'd1,
    VEC_LO = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [0:0] {
    RUN = 1'b0
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_field_split.sv
// Slices a 16-bit instruction word into opcode/Rs/Rd/shmnt; an invalid slot yields an all-zero NOP.
module fetch_field_split
  import fetch_unit_pkg::*;
(
  input  logic [INST_W-1:0]   inst,
  input  logic                valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    Rs,
  output logic [REG_W-1:0]    Rd,
  output logic [SHMNT_W-1:0]  shmnt
);

  // Field extraction with valid gating
  always_comb begin
    opcode = NOP_OPCODE;
    Rs     = 3'd0;
    Rd     = 3'd0;
    shmnt  = 5'd0;
    if (valid) begin
      opcode = inst[OPCODE_LSB +: OPCODE_W];
      Rs     = inst[RS_LSB +: REG_W];
      Rd     = inst[RD_LSB +: REG_W];
      shmnt  = inst[SHMNT_LSB +: SHMNT_W];
    end else begin
      opcode = NOP_OPCODE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, stall hold, branch redirect with one-slot squash.
// Define FETCH_RESET_VECTOR_EN to load the start PC from memory words 0 and 1 after reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INST_W-1:0]   imem_rdata,
  output logic [ADDR_W-1:0]   Next_inst_addr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    Rs,
  output logic [REG_W-1:0]    Rd,
  output logic [SHMNT_W-1:0]  shmnt,
  output logic                inst_valid
);

`ifdef FETCH_RESET_VECTOR_EN
  localparam fetch_state_e        START_STATE = VEC_HI;
  localparam logic [ADDR_W-1:0]   START_PC    = 32'h0000_0000;
`else
  localparam fetch_state_e        START_STATE = RUN;
  localparam logic [ADDR_W-1:0]   START_PC    = RESET_PC;
`endif

  fetch_state_e      state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] inflight_pc_r, inflight_pc_s;
  logic              inflight_vld_r, inflight_vld_s;
  // The memory re-reads the PC while stalled, so the slot's word is parked here.
  logic              held_r, held_s;
  logic [INST_W-1:0] held_word_r, held_word_s;
  logic [INST_W-1:0] word_s;
`ifdef FETCH_RESET_VECTOR_EN
  logic [INST_W-1:0] vec_hi_r, vec_hi_s;
`endif

  // Next-state and next-PC selection
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    inflight_pc_s  = inflight_pc_r;
    inflight_vld_s = inflight_vld_r;
    held_s         = held_r;
    held_word_s    = held_word_r;
`ifdef FETCH_RESET_VECTOR_EN
    vec_hi_s       = vec_hi_r;
`endif
    case (state_r)
      RUN: begin
        if (branch_taken) begin
          pc_s           = branch_target;
          inflight_vld_s = 1'b0;
          held_s         = 1'b0;
        end else if (stall) begin
          if (!held_r) begin
            held_s      = 1'b1;
            held_word_s = imem_rdata;
          end else begin
            held_s      = 1'b1;
          end
        end else begin
          inflight_pc_s  = pc_r;
          inflight_vld_s = 1'b1;
          pc_s           = pc_r + 32'd1;
          held_s         = 1'b0;
        end
      end
`ifdef FETCH_RESET_VECTOR_EN
      VEC_HI: begin
        vec_hi_s = imem_rdata;
        pc_s     = 32'd1;
        state_s  = VEC_LO;
      end
      VEC_LO: begin
        pc_s    = {vec_hi_r, imem_rdata};
        state_s = RUN;
      end
`endif
      default: begin
        state_s        = RUN;
        inflight_vld_s = 1'b0;
        held_s         = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= START_STATE;
      pc_r           <= START_PC;
      inflight_pc_r  <= 32'd0;
      inflight_vld_r <= 1'b0;
      held_r         <= 1'b0;
      held_word_r    <= 16'd0;
`ifdef FETCH_RESET_VECTOR_EN
      vec_hi_r       <= 16'd0;
`endif
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      inflight_pc_r  <= inflight_pc_s;
      inflight_vld_r <= inflight_vld_s;
      held_r         <= held_s;
      held_word_r    <= held_word_s;
`ifdef FETCH_RESET_VECTOR_EN
      vec_hi_r       <= vec_hi_s;
`endif
    end
  end

  assign imem_addr      = pc_r;
  assign inst_valid     = inflight_vld_r;
  assign Next_inst_addr = inflight_vld_r ? (inflight_pc_r + 32'd1) : 32'd0;
  assign word_s         = held_r ? held_word_r : imem_rdata;

  fetch_field_split u_split (
    .inst   (word_s),
    .valid  (inflight_vld_r),
    .opcode (opcode),
    .Rs     (Rs),
    .Rd     (Rd),
    .shmnt  (shmnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): sequential fetch, stall, redirect,
// stall+redirect, PC wrap and asynchronous mid-stream reset against a registered memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [31:0] Next_inst_addr;
  logic [4:0]  opcode;
  logic [2:0]  Rs;
  logic [2:0]  Rd;
  logic [4:0]  shmnt;
  logic        inst_valid;

  int n_vec  = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .Next_inst_addr (Next_inst_addr),
    .opcode         (opcode),
    .Rs             (Rs),
    .Rd             (Rd),
    .shmnt          (shmnt),
    .inst_valid     (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 16'h0901;
      32'h0000_0001: mem_word = 16'h1A22;
      32'h0000_0002: mem_word = 16'h2B43;
      32'h0000_0003: mem_word = 16'h3C64;
      32'h0000_0040: mem_word = 16'hA8E5;
      default:       mem_word = {a[7:0], ~a[7:0]};
    endcase
  endfunction

  // One-cycle-latency instruction memory
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",   imem_addr, 32'd0);
    chk("rst_valid",  {31'd0, inst_valid}, 32'd0);
    chk("rst_next",   Next_inst_addr, 32'd0);
    chk("rst_opcode", {27'd0, opcode}, 32'd0);
    rst = 1'b0;
    chk("c0_addr", imem_addr, 32'd0);

    step();
    chk("c1_addr",   imem_addr, 32'd1);
    chk("c1_opcode", {27'd0, opcode}, 32'd1);
    chk("c1_rs",     {29'd0, Rs}, 32'd1);
    chk("c1_rd",     {29'd0, Rd}, 32'd0);
    chk("c1_shmnt",  {27'd0, shmnt}, 32'd1);
    chk("c1_next",   Next_inst_addr, 32'd1);
    chk("c1_valid",  {31'd0, inst_valid}, 32'd1);

    step();
    chk("c2_addr",   imem_addr, 32'd2);
    chk("c2_opcode", {27'd0, opcode}, 32'd3);
    chk("c2_rs",     {29'd0, Rs}, 32'd2);
    chk("c2_rd",     {29'd0, Rd}, 32'd1);
    chk("c2_shmnt",  {27'd0, shmnt}, 32'd2);
    chk("c2_next",   Next_inst_addr, 32'd2);

    step();
    chk("c3_addr",   imem_addr, 32'd3);
    chk("c3_opcode", {27'd0, opcode}, 32'd5);
    chk("c3_next",   Next_inst_addr, 32'd3);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",   imem_addr, 32'd3);
      chk("stall_next",   Next_inst_addr, 32'd3);
      chk("stall_opcode", {27'd0, opcode}, 32'd5);
      chk("stall_rs",     {29'd0, Rs}, 32'd3);
      chk("stall_rd",     {29'd0, Rd}, 32'd2);
      chk("stall_shmnt",  {27'd0, shmnt}, 32'd3);
      chk("stall_valid",  {31'd0, inst_valid}, 32'd1);
    end
    stall = 1'b0;

    step();
    chk("resume_addr",   imem_addr, 32'd4);
    chk("resume_next",   Next_inst_addr, 32'd4);
    chk("resume_opcode", {27'd0, opcode}, 32'd7);
    chk("resume_rs",     {29'd0, Rs}, 32'd4);
    chk("resume_rd",     {29'd0, Rd}, 32'd3);
    chk("resume_shmnt",  {27'd0, shmnt}, 32'd4);

    step();
    chk("pc5_addr", imem_addr, 32'd5);
    chk("pc5_next", Next_inst_addr, 32'd5);

    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    chk("br_bub_valid",  {31'd0, inst_valid}, 32'd0);
    chk("br_bub_opcode", {27'd0, opcode}, 32'd0);
    chk("br_bub_rs",     {29'd0, Rs}, 32'd0);
    chk("br_bub_rd",     {29'd0, Rd}, 32'd0);
    chk("br_bub_shmnt",  {27'd0, shmnt}, 32'd0);
    chk("br_bub_next",   Next_inst_addr, 32'd0);
    chk("br_bub_addr",   imem_addr, 32'h40);

    step();
    chk("br_tgt_valid",  {31'd0, inst_valid}, 32'd1);
    chk("br_tgt_next",   Next_inst_addr, 32'h41);
    chk("br_tgt_opcode", {27'd0, opcode}, 32'd21);
    chk("br_tgt_rs",     {29'd0, Rs}, 32'd0);
    chk("br_tgt_rd",     {29'd0, Rd}, 32'd7);
    chk("br_tgt_shmnt",  {27'd0, shmnt}, 32'd5);
    chk("br_tgt_addr",   imem_addr, 32'h41);

    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h10;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    chk("sb_addr",  imem_addr, 32'h10);
    chk("sb_valid", {31'd0, inst_valid}, 32'd0);

    step();
    chk("sb_tgt_valid",  {31'd0, inst_valid}, 32'd1);
    chk("sb_tgt_next",   Next_inst_addr, 32'h11);
    chk("sb_tgt_addr",   imem_addr, 32'h11);
    chk("sb_tgt_opcode", {27'd0, opcode}, 32'd2);
    chk("sb_tgt_rd",     {29'd0, Rd}, 32'd7);
    chk("sb_tgt_shmnt",  {27'd0, shmnt}, 32'd15);

    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    chk("wrap_addr0",  imem_addr, 32'hFFFF_FFFF);
    chk("wrap_valid0", {31'd0, inst_valid}, 32'd0);

    step();
    chk("wrap_addr1",  imem_addr, 32'd0);
    chk("wrap_next",   Next_inst_addr, 32'd0);
    chk("wrap_valid1", {31'd0, inst_valid}, 32'd1);
    chk("wrap_opcode", {27'd0, opcode}, 32'd31);
    chk("wrap_rs",     {29'd0, Rs}, 32'd7);

    step();
    chk("post_wrap_addr",   imem_addr, 32'd1);
    chk("post_wrap_next",   Next_inst_addr, 32'd1);
    chk("post_wrap_opcode", {27'd0, opcode}, 32'd1);

    #3;
    rst = 1'b1;
    #1;
    chk("arst_addr",   imem_addr, 32'd0);
    chk("arst_valid",  {31'd0, inst_valid}, 32'd0);
    chk("arst_next",   Next_inst_addr, 32'd0);
    chk("arst_opcode", {27'd0, opcode}, 32'd0);
    chk("arst_shmnt",  {27'd0, shmnt}, 32'd0);
    step();
    rst = 1'b0;
    chk("rel_addr",  imem_addr, 32'd0);
    chk("rel_valid", {31'd0, inst_valid}, 32'd0);

    step();
    chk("rel1_addr",   imem_addr, 32'd1);
    chk("rel1_valid",  {31'd0, inst_valid}, 32'd1);
    chk("rel1_next",   Next_inst_addr, 32'd1);
    chk("rel1_opcode", {27'd0, opcode}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
